// File: rtl/rx_frame_pkg.sv
// Shared state encoding and error-bit positions for the serial-frame receive controller.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_PARITY  = 1;

endpackage

// File: rtl/rx_frame_ctrl.sv
// Parametrised serial-frame receive controller: start-bit validation, LSB-first data,
// optional parity, configurable stop bits, framing/parity errors, Tx collision flag.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rx_En_Sig,
    input  logic              Bus_Idle,
    input  logic              H2L_Sig,
    input  logic              Rx_Pin_In,
    input  logic              BPS_CLK,
    input  logic              Tx_Transmit_now,
    input  logic              Tx_Pin_to_Rx,
    output logic              Count_Sig,
    output logic              Start_Rx,
    output logic [DATA_W-1:0] Rx_Data,
    output logic              Rx_Done_Sig,
    output logic              Rx_Err_Sig,
    output logic [1:0]        Err_Code,
    output logic              Tx_Cancel
);

    localparam int               CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic             PAR_ON    = (PARITY_EN != 0);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    rx_state_t         state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [1:0]        stop_cnt, stop_cnt_nx;
    logic [DATA_W-1:0] shift_reg, shift_nx;
    logic              parity_acc, parity_nx;
    logic [DATA_W-1:0] data_nx;
    logic [1:0]        err_nx;
    logic              count_nx, start_nx, done_nx, cancel_nx;
    logic              collision;

    assign collision = Tx_Transmit_now & (Tx_Pin_to_Rx != Rx_Pin_In);

    // Next-state and next-output logic; abort on enable loss outranks every BPS sample.
    // Done/data/error are set on entry to DONE so they appear the cycle after the last
    // stop sample; Count_Sig and Tx_Cancel clear on leaving DONE.
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        stop_cnt_nx = stop_cnt;
        shift_nx    = shift_reg;
        parity_nx   = parity_acc;
        data_nx     = Rx_Data;
        err_nx      = Err_Code;
        count_nx    = Count_Sig;
        start_nx    = Start_Rx;
        done_nx     = 1'b0;
        cancel_nx   = Tx_Cancel;

        if (state != IDLE && !Rx_En_Sig) begin
            state_nx  = IDLE;
            count_nx  = 1'b0;
            start_nx  = 1'b0;
            cancel_nx = 1'b0;
            err_nx    = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (H2L_Sig && Rx_En_Sig && Bus_Idle) begin
                        state_nx    = START;
                        count_nx    = 1'b1;
                        start_nx    = 1'b1;
                        err_nx      = 2'b00;
                        parity_nx   = 1'b0;
                        bit_cnt_nx  = '0;
                        stop_cnt_nx = 2'd0;
                    end
                end
                START: begin
                    if (BPS_CLK) begin
                        start_nx   = 1'b0;
                        bit_cnt_nx = '0;
                        if (Rx_Pin_In) begin
                            state_nx = IDLE;
                            count_nx = 1'b0;
                        end else begin
                            state_nx = DATA;
                        end
                    end
                end
                DATA: begin
                    if (BPS_CLK) begin
                        // Right-shifting in at the MSB lands the first bit at bit 0 after DATA_W samples.
                        shift_nx  = (shift_reg >> 1) | (DATA_W'(Rx_Pin_In) << (DATA_W - 1));
                        parity_nx = parity_acc ^ Rx_Pin_In;
                        if (collision) begin
                            cancel_nx = 1'b1;
                        end
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_nx = '0;
                            state_nx   = PAR_ON ? PARITY : STOP;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (BPS_CLK) begin
                        if (Rx_Pin_In != (parity_acc ^ PAR_ODD)) begin
                            err_nx[ERR_PARITY] = 1'b1;
                        end
                        if (collision) begin
                            cancel_nx = 1'b1;
                        end
                        state_nx = STOP;
                    end
                end
                STOP: begin
                    if (BPS_CLK) begin
                        if (!Rx_Pin_In) begin
                            err_nx[ERR_FRAMING] = 1'b1;
                        end
                        if (stop_cnt == LAST_STOP) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            data_nx  = shift_reg;
                        end else begin
                            stop_cnt_nx = stop_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nx  = IDLE;
                    count_nx  = 1'b0;
                    cancel_nx = 1'b0;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            stop_cnt    <= 2'd0;
            shift_reg   <= '0;
            parity_acc  <= 1'b0;
            Rx_Data     <= '0;
            Err_Code    <= 2'b00;
            Rx_Err_Sig  <= 1'b0;
            Count_Sig   <= 1'b0;
            Start_Rx    <= 1'b0;
            Rx_Done_Sig <= 1'b0;
            Tx_Cancel   <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            stop_cnt    <= stop_cnt_nx;
            shift_reg   <= shift_nx;
            parity_acc  <= parity_nx;
            Rx_Data     <= data_nx;
            Err_Code    <= err_nx;
            Rx_Err_Sig  <= |err_nx;
            Count_Sig   <= count_nx;
            Start_Rx    <= start_nx;
            Rx_Done_Sig <= done_nx;
            Tx_Cancel   <= cancel_nx;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: a 32-bit/no-parity instance (a) and an
// 8-bit/even-parity instance (b), both with two stop bits.
module tb_rx_frame_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Rx_En_Sig = 1'b1;
    logic Bus_Idle = 1'b1;
    logic h2l = 1'b0;
    logic pin = 1'b1;
    logic bps = 1'b0;
    logic tx_now = 1'b0;
    logic tx_pin = 1'b0;
    logic sel = 1'b0;

    logic        a_count, a_start, a_done, a_err, a_cancel;
    logic [1:0]  a_code;
    logic [31:0] a_data;
    logic        b_count, b_start, b_done, b_err, b_cancel;
    logic [1:0]  b_code;
    logic [7:0]  b_data;
    logic [6:0]  st_a, st_b;

    int tests_run = 0;
    int tests_failed = 0;
    int done_a_cnt = 0;
    int done_b_cnt = 0;
    int snap;

    always #5 CLK = ~CLK;

    // Status vectors: {Count_Sig, Start_Rx, Rx_Done_Sig, Rx_Err_Sig, Err_Code[1:0], Tx_Cancel}
    assign st_a = {a_count, a_start, a_done, a_err, a_code, a_cancel};
    assign st_b = {b_count, b_start, b_done, b_err, b_code, b_cancel};

    rx_frame_ctrl #(.DATA_W(32), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_a (
        .CLK(CLK), .RST(RST), .Rx_En_Sig(Rx_En_Sig), .Bus_Idle(Bus_Idle),
        .H2L_Sig(h2l & ~sel), .Rx_Pin_In(pin), .BPS_CLK(bps & ~sel),
        .Tx_Transmit_now(tx_now), .Tx_Pin_to_Rx(tx_pin),
        .Count_Sig(a_count), .Start_Rx(a_start), .Rx_Data(a_data), .Rx_Done_Sig(a_done),
        .Rx_Err_Sig(a_err), .Err_Code(a_code), .Tx_Cancel(a_cancel)
    );

    rx_frame_ctrl #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .Rx_En_Sig(Rx_En_Sig), .Bus_Idle(Bus_Idle),
        .H2L_Sig(h2l & sel), .Rx_Pin_In(pin), .BPS_CLK(bps & sel),
        .Tx_Transmit_now(tx_now), .Tx_Pin_to_Rx(tx_pin),
        .Count_Sig(b_count), .Start_Rx(b_start), .Rx_Data(b_data), .Rx_Done_Sig(b_done),
        .Rx_Err_Sig(b_err), .Err_Code(b_code), .Tx_Cancel(b_cancel)
    );

    // Count Done pulses per instance.
    always @(posedge CLK) begin
        if (a_done) done_a_cnt <= done_a_cnt + 1;
        if (b_done) done_b_cnt <= done_b_cnt + 1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame();
        pin = 1'b0;
        h2l = 1'b1;
        step();
        h2l = 1'b0;
    endtask

    task automatic pulse_bit(input logic v);
        pin = v;
        step();
        bps = 1'b1;
        step();
        bps = 1'b0;
    endtask

    task automatic send_body(input logic [63:0] data, input int nbits, input bit has_par,
                             input logic par, input logic stop0, input logic stop1);
        pulse_bit(1'b0);
        for (int i = 0; i < nbits; i++) pulse_bit(data[i[5:0]]);
        if (has_par) pulse_bit(par);
        pulse_bit(stop0);
        pulse_bit(stop1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL reset_status_a: got %b expected %b", st_a, 7'b0000000); end
        tests_run++;
        if (a_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data_a: got %h expected %h", a_data, 32'h0); end
        tests_run++;
        if (st_b !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL reset_status_b: got %b expected %b", st_b, 7'b0000000); end
        tests_run++;
        if (b_data !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_data_b: got %h expected %h", b_data, 8'h0); end
    endtask

    task automatic test_frame32();
        logic [63:0] d = 64'hA5C3_0F1E;
        sel = 1'b0;
        snap = done_a_cnt;
        start_frame();
        tests_run++;
        if (st_a !== 7'b1100000) begin tests_failed++; $display("[TB] FAIL f32_start: got %b expected %b", st_a, 7'b1100000); end
        pulse_bit(1'b0);
        tests_run++;
        if (st_a !== 7'b1000000) begin tests_failed++; $display("[TB] FAIL f32_startbit: got %b expected %b", st_a, 7'b1000000); end
        for (int i = 0; i < 32; i++) pulse_bit(d[i[5:0]]);
        pulse_bit(1'b1);
        pulse_bit(1'b1);
        tests_run++;
        if (st_a !== 7'b1010000) begin tests_failed++; $display("[TB] FAIL f32_done: got %b expected %b", st_a, 7'b1010000); end
        tests_run++;
        if (a_data !== 32'hA5C3_0F1E) begin tests_failed++; $display("[TB] FAIL f32_data: got %h expected %h", a_data, 32'hA5C3_0F1E); end
        step();
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL f32_after: got %b expected %b", st_a, 7'b0000000); end
        step();
        tests_run++;
        if (done_a_cnt - snap !== 1) begin tests_failed++; $display("[TB] FAIL f32_pulses: got %0d expected %0d", done_a_cnt - snap, 1); end
    endtask

    task automatic test_parity8();
        sel = 1'b1;
        start_frame();
        send_body(64'h07, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (st_b !== 7'b1011100) begin tests_failed++; $display("[TB] FAIL p8_parity_err: got %b expected %b", st_b, 7'b1011100); end
        tests_run++;
        if (b_data !== 8'h07) begin tests_failed++; $display("[TB] FAIL p8_data: got %h expected %h", b_data, 8'h07); end
        step();
        tests_run++;
        if ({b_count, b_done} !== 2'b00) begin tests_failed++; $display("[TB] FAIL p8_after: got %b expected %b", {b_count, b_done}, 2'b00); end
        step();
        start_frame();
        tests_run++;
        if (st_b !== 7'b1100000) begin tests_failed++; $display("[TB] FAIL p8_err_clear: got %b expected %b", st_b, 7'b1100000); end
        send_body(64'h07, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (st_b !== 7'b1011010) begin tests_failed++; $display("[TB] FAIL p8_framing_err: got %b expected %b", st_b, 7'b1011010); end
        step();
        step();
    endtask

    task automatic test_glitch();
        sel = 1'b0;
        snap = done_a_cnt;
        start_frame();
        pulse_bit(1'b1);
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL glitch_status: got %b expected %b", st_a, 7'b0000000); end
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (a_data !== 32'hA5C3_0F1E) begin tests_failed++; $display("[TB] FAIL glitch_data: got %h expected %h", a_data, 32'hA5C3_0F1E); end
        tests_run++;
        if (done_a_cnt - snap !== 0) begin tests_failed++; $display("[TB] FAIL glitch_pulses: got %0d expected %0d", done_a_cnt - snap, 0); end
    endtask

    task automatic test_collision();
        logic [63:0] d = 64'hFFFF_FFDF;
        sel = 1'b0;
        tx_now = 1'b1;
        tx_pin = 1'b1;
        start_frame();
        pulse_bit(1'b0);
        for (int i = 0; i < 5; i++) pulse_bit(d[i[5:0]]);
        tests_run++;
        if (st_a !== 7'b1000000) begin tests_failed++; $display("[TB] FAIL coll_before: got %b expected %b", st_a, 7'b1000000); end
        pulse_bit(d[5]);
        tests_run++;
        if (st_a !== 7'b1000001) begin tests_failed++; $display("[TB] FAIL coll_set: got %b expected %b", st_a, 7'b1000001); end
        for (int i = 6; i < 32; i++) pulse_bit(d[i[5:0]]);
        pulse_bit(1'b1);
        tests_run++;
        if (st_a !== 7'b1000001) begin tests_failed++; $display("[TB] FAIL coll_hold: got %b expected %b", st_a, 7'b1000001); end
        pulse_bit(1'b1);
        tests_run++;
        if (st_a !== 7'b1010001) begin tests_failed++; $display("[TB] FAIL coll_done: got %b expected %b", st_a, 7'b1010001); end
        tests_run++;
        if (a_data !== 32'hFFFF_FFDF) begin tests_failed++; $display("[TB] FAIL coll_data: got %h expected %h", a_data, 32'hFFFF_FFDF); end
        step();
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL coll_clear: got %b expected %b", st_a, 7'b0000000); end
        tx_now = 1'b0;
    endtask

    task automatic test_abort();
        logic [63:0] d = 64'hFFFF_FFDF;
        sel = 1'b0;
        tx_now = 1'b1;
        tx_pin = 1'b1;
        snap = done_a_cnt;
        start_frame();
        pulse_bit(1'b0);
        for (int i = 0; i < 10; i++) pulse_bit(d[i[5:0]]);
        tests_run++;
        if (st_a !== 7'b1000001) begin tests_failed++; $display("[TB] FAIL abort_pre: got %b expected %b", st_a, 7'b1000001); end
        pin = d[10];
        step();
        Rx_En_Sig = 1'b0;
        bps = 1'b1;
        step();
        bps = 1'b0;
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL abort_status: got %b expected %b", st_a, 7'b0000000); end
        tests_run++;
        if (a_data !== 32'hFFFF_FFDF) begin tests_failed++; $display("[TB] FAIL abort_data: got %h expected %h", a_data, 32'hFFFF_FFDF); end
        step();
        step();
        tests_run++;
        if (done_a_cnt - snap !== 0) begin tests_failed++; $display("[TB] FAIL abort_pulses: got %0d expected %0d", done_a_cnt - snap, 0); end
        Rx_En_Sig = 1'b1;
        tx_now = 1'b0;
        step();
        start_frame();
        send_body(64'h1357_9BDF, 32, 1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (st_a !== 7'b1010000) begin tests_failed++; $display("[TB] FAIL abort_next_done: got %b expected %b", st_a, 7'b1010000); end
        tests_run++;
        if (a_data !== 32'h1357_9BDF) begin tests_failed++; $display("[TB] FAIL abort_next_data: got %h expected %h", a_data, 32'h1357_9BDF); end
        step();
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        start_frame();
        send_body(64'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (st_b !== 7'b1010000) begin tests_failed++; $display("[TB] FAIL b2b_first: got %b expected %b", st_b, 7'b1010000); end
        tests_run++;
        if (b_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL b2b_first_data: got %h expected %h", b_data, 8'h5A); end
        start_frame();
        tests_run++;
        if ({b_count, b_start} !== 2'b00) begin tests_failed++; $display("[TB] FAIL b2b_h2l_in_done: got %b expected %b", {b_count, b_start}, 2'b00); end
        start_frame();
        tests_run++;
        if (st_b !== 7'b1100000) begin tests_failed++; $display("[TB] FAIL b2b_restart: got %b expected %b", st_b, 7'b1100000); end
        send_body(64'hC3, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (st_b !== 7'b1010000) begin tests_failed++; $display("[TB] FAIL b2b_second: got %b expected %b", st_b, 7'b1010000); end
        tests_run++;
        if (b_data !== 8'hC3) begin tests_failed++; $display("[TB] FAIL b2b_second_data: got %h expected %h", b_data, 8'hC3); end
        step();
    endtask

    task automatic test_reset_midframe();
        logic [63:0] d = 64'h0F0F_0F0F;
        sel = 1'b0;
        start_frame();
        pulse_bit(1'b0);
        for (int i = 0; i < 32; i++) pulse_bit(d[i[5:0]]);
        pulse_bit(1'b1);
        tests_run++;
        if (st_a !== 7'b1000000) begin tests_failed++; $display("[TB] FAIL rst_pre: got %b expected %b", st_a, 7'b1000000); end
        pin = 1'b1;
        step();
        RST = 1'b1;
        bps = 1'b1;
        step();
        RST = 1'b0;
        bps = 1'b0;
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL rst_status: got %b expected %b", st_a, 7'b0000000); end
        tests_run++;
        if (a_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_data: got %h expected %h", a_data, 32'h0); end
        step();
        Bus_Idle = 1'b0;
        start_frame();
        tests_run++;
        if (st_a !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL busy_no_start: got %b expected %b", st_a, 7'b0000000); end
        Bus_Idle = 1'b1;
        pin = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_frame32();
        test_parity8();
        test_glitch();
        test_collision();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
